rr_trace_wb_ctrl: RTL and testbench
===================================

// Module: rr_trace_wb_ctrl
// PURPOSE
//   Sequences record-log writeback: drains merged AXI_WIDTH-bit words from the merge output FIFO and
//   issues AXI4 INCR write bursts into a DRAM trace buffer [buf_base, buf_base+buf_size).
//   Sits between the trace-merge output FIFO and the DDR/PCIS AXI write port; flushes on record_finish.
// PARAMETERS
//   AXI_WIDTH       512  data beat width (bits); beat bytes BB = AXI_WIDTH/8
//   AXI_ADDR_WIDTH  64   AXI address width
//   OFFSET_WIDTH    32   width of per-word valid-size field (bits)
//   BURST_LEN       16   max beats per burst; BURST_LEN*BB must divide 4096
//   CNT_WIDTH       10   width of fifo_cnt
// PORTS
//   clk            in   1               clock
//   rst_n          in   1               asynchronous active-low reset
//   cfg_start      in   1               pulse: latch buf_base/buf_size, clear counters, enter WAIT
//   buf_base       in   AXI_ADDR_WIDTH  buffer base, 4 KiB aligned
//   buf_size       in   AXI_ADDR_WIDTH  buffer bytes, multiple of BURST_LEN*BB, nonzero
//   record_finish  in   1               pulse: flush remaining words, then finish
//   fifo_dout      in   AXI_WIDTH       FWFT FIFO head word
//   fifo_size      in   OFFSET_WIDTH    valid bits in head word (1..AXI_WIDTH, multiple of 8)
//   fifo_cnt       in   CNT_WIDTH       words in FIFO
//   fifo_empty     in   1               FIFO empty
//   fifo_rd_en     out  1               pop head word
//   awaddr/awlen/awvalid  out  AXI_ADDR_WIDTH/8/1;  awready  in 1
//   wdata/wstrb/wlast/wvalid  out  AXI_WIDTH/BB/1/1;  wready  in 1
//   bresp in 2, bvalid in 1, bready out 1
//   wr_bytes       out  AXI_ADDR_WIDTH  total bytes acknowledged (B received) since cfg_start
//   busy/done/err/buf_full  out  1 each  status
// BEHAVIOUR
//   - Reset (async, immediate): state IDLE; all outputs 0; wr_ptr, wr_bytes, latched cfg cleared.
//     Reset mid-burst drops valids at once; only allowed AXI violation.
//   - FSM IDLE -> (cfg_start) WAIT -> AW -> W -> B -> WAIT | DONE. cfg_start ignored outside IDLE/DONE;
//     in DONE it restarts (counters cleared, done=0).
//   - WAIT: issue burst when fifo_cnt>=BURST_LEN (len=BURST_LEN), or when flushing and fifo_cnt>0
//     (len=min(fifo_cnt,BURST_LEN)); beats latched at AW entry. Flushing and fifo_empty -> DONE.
//     Full-burst rule wins over flush when both hold.
//   - AW: awvalid=1, awaddr=wr_ptr, awlen=beats-1; hold stable until awready. One burst outstanding.
//   - W: wvalid=~fifo_empty; wdata=fifo_dout; fifo_rd_en=wvalid&wready; wlast on final beat;
//     wstrb=(1<<(fifo_size/8))-1, all ones when fifo_size>=AXI_WIDTH. Beat counter decrements per handshake.
//   - B: bready=1; on bvalid: wr_bytes+=beats*BB; bresp!=0 sets sticky err (no retry); wr_ptr+=beats*BB.
//   - wr_ptr is byte address; bursts never cross 4 KiB (alignment rules above). Partial final
//     bursts only at flush, so wrap point always lands on a burst boundary.
//   - record_finish latched sticky (flushing) in any non-IDLE state, including same cycle as a burst
//     decision; it does not abort an in-flight burst.
//   - busy=1 in WAIT/AW/W/B; done=1 only in DONE (one cycle after last B or flush-empty).
//   - Buffer end: when wr_ptr==base+size after a B, behaviour per CONFIGURATION.
//   - Latency: WAIT->awvalid 1 cycle after burst condition registers; min burst = 1+beats+1 cycles.
// CONFIGURATION
//   RR_TRACE_WB_WRAP_EN defined: wr_ptr wraps to buf_base at end (ring); buf_full pulses 1 cycle per
//     wrap; wr_bytes keeps counting (monotonic).
//   Undefined: at end go to WAIT-stalled; no further AW, fifo_rd_en=0 (upstream backpressure);
//     buf_full sticky until cfg_start/reset; flush with data pending -> DONE with err=1.
// TESTING
//   1. base=0x1000,size=0x8000, fifo_cnt=16 full words, aw/w ready -> one AW awaddr=0x1000,awlen=15,
//      16 beats, wlast on 16th, wr_bytes=1024 after B.
//   2. 5 words then record_finish, last fifo_size=96 -> burst awlen=4, last wstrb=0xFFF, done=1.
//   3. awready held 0 for 10 cycles, wready toggling 50% -> awaddr/awlen stable, no beat lost/duplicated.
//   4. bresp=2'b10 on burst 2 of 3 -> err=1 sticky, all 3 bursts still written, done=1 at flush.
//   5. size=0x800, 3 full bursts: WRAP_EN -> 3rd awaddr=base, buf_full pulse; else stall, buf_full=1,
//      fifo_rd_en=0.
//   6. rst_n asserted mid-W -> awvalid/wvalid/fifo_rd_en=0 same cycle; after release IDLE, wr_bytes=0.

Source files
------------

// File: rtl/rr_trace_wb_ctrl_if.sv
// AXI4 write-channel bundle (AW/W/B) between the trace writeback sequencer and the DRAM port.
interface rr_trace_wb_ctrl_if #(
   parameter int unsigned AXI_WIDTH      = 512,
   parameter int unsigned AXI_ADDR_WIDTH = 64
);
   localparam int unsigned BB = AXI_WIDTH / 8;

   logic [AXI_ADDR_WIDTH-1:0] awaddr;
   logic [7:0]                awlen;
   logic                      awvalid;
   logic                      awready;
   logic [AXI_WIDTH-1:0]      wdata;
   logic [BB-1:0]             wstrb;
   logic                      wlast;
   logic                      wvalid;
   logic                      wready;
   logic [1:0]                bresp;
   logic                      bvalid;
   logic                      bready;

   modport master (
      output awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
      input  awready, wready, bresp, bvalid
   );

   modport slave (
      input  awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
      output awready, wready, bresp, bvalid
   );
endinterface

// File: rtl/rr_trace_wb_ctrl.sv
// Trace-log writeback sequencer: drains the merge FIFO into AXI4 INCR bursts over a DRAM buffer.
// Define RR_TRACE_WB_WRAP_EN for ring-buffer wrap; otherwise the buffer stalls when full.
module rr_trace_wb_ctrl #(
   parameter int unsigned AXI_WIDTH      = 512,
   parameter int unsigned AXI_ADDR_WIDTH = 64,
   parameter int unsigned OFFSET_WIDTH   = 32,
   parameter int unsigned BURST_LEN      = 16,
   parameter int unsigned CNT_WIDTH      = 10
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      i_cfg_start,
   input  logic [AXI_ADDR_WIDTH-1:0] i_buf_base,
   input  logic [AXI_ADDR_WIDTH-1:0] i_buf_size,
   input  logic                      i_record_finish,
   input  logic [AXI_WIDTH-1:0]      i_fifo_dout,
   input  logic [OFFSET_WIDTH-1:0]   i_fifo_size,
   input  logic [CNT_WIDTH-1:0]      i_fifo_cnt,
   input  logic                      i_fifo_empty,
   output logic                      o_fifo_rd_en,
   rr_trace_wb_ctrl_if.master        m_axi,
   output logic [AXI_ADDR_WIDTH-1:0] o_wr_bytes,
   output logic                      o_busy,
   output logic                      o_done,
   output logic                      o_err,
   output logic                      o_buf_full
);

   localparam int unsigned BB     = AXI_WIDTH / 8;
   localparam int unsigned BEAT_W = $clog2(BURST_LEN + 1);
   localparam logic [AXI_ADDR_WIDTH-1:0] BB_A = AXI_ADDR_WIDTH'(BB);

   typedef enum logic [2:0] {StIdle, StWait, StAw, StW, StB, StDone} state_e;

   state_e                    r_state, w_state_nxt;
   logic [AXI_ADDR_WIDTH-1:0] r_base, w_base_nxt;
   logic [AXI_ADDR_WIDTH-1:0] r_end, w_end_nxt;
   logic [AXI_ADDR_WIDTH-1:0] r_ptr, w_ptr_nxt;
   logic [AXI_ADDR_WIDTH-1:0] r_bytes, w_bytes_nxt;
   logic [BEAT_W-1:0]         r_beats, w_beats_nxt;
   logic [BEAT_W-1:0]         r_cnt, w_cnt_nxt;
   logic                      r_flush, w_flush_nxt;
   logic                      r_err, w_err_nxt;
`ifdef RR_TRACE_WB_WRAP_EN
   logic                      r_wrap_pulse, w_wrap_pulse_nxt;
`else
   logic                      r_full, w_full_nxt;
`endif

   logic                      w_flush_now;
   logic                      w_wvalid;
   logic                      w_hs;
   logic [AXI_ADDR_WIDTH-1:0] w_burst_bytes;
   logic [AXI_ADDR_WIDTH-1:0] w_ptr_inc;
   logic [OFFSET_WIDTH-1:0]   w_size_bytes;
   logic [BB-1:0]             w_strb;

   assign w_flush_now   = r_flush | (i_record_finish & (r_state != StIdle));
   assign w_wvalid      = (r_state == StW) & ~i_fifo_empty;
   assign w_hs          = w_wvalid & m_axi.wready;
   assign w_burst_bytes = AXI_ADDR_WIDTH'(r_beats) * BB_A;
   assign w_ptr_inc     = r_ptr + w_burst_bytes;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= StIdle;
         r_base       <= '0;
         r_end        <= '0;
         r_ptr        <= '0;
         r_bytes      <= '0;
         r_beats      <= '0;
         r_cnt        <= '0;
         r_flush      <= 1'b0;
         r_err        <= 1'b0;
`ifdef RR_TRACE_WB_WRAP_EN
         r_wrap_pulse <= 1'b0;
`else
         r_full       <= 1'b0;
`endif
      end else begin
         r_state      <= w_state_nxt;
         r_base       <= w_base_nxt;
         r_end        <= w_end_nxt;
         r_ptr        <= w_ptr_nxt;
         r_bytes      <= w_bytes_nxt;
         r_beats      <= w_beats_nxt;
         r_cnt        <= w_cnt_nxt;
         r_flush      <= w_flush_nxt;
         r_err        <= w_err_nxt;
`ifdef RR_TRACE_WB_WRAP_EN
         r_wrap_pulse <= w_wrap_pulse_nxt;
`else
         r_full       <= w_full_nxt;
`endif
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_base_nxt  = r_base;
      w_end_nxt   = r_end;
      w_ptr_nxt   = r_ptr;
      w_bytes_nxt = r_bytes;
      w_beats_nxt = r_beats;
      w_cnt_nxt   = r_cnt;
      w_flush_nxt = w_flush_now;
      w_err_nxt   = r_err;
`ifdef RR_TRACE_WB_WRAP_EN
      w_wrap_pulse_nxt = 1'b0;
`else
      w_full_nxt       = r_full;
`endif
      unique case (r_state)
         StIdle, StDone: begin
            if (i_cfg_start) begin
               w_base_nxt  = i_buf_base;
               w_end_nxt   = i_buf_base + i_buf_size;
               w_ptr_nxt   = i_buf_base;
               w_bytes_nxt = '0;
               w_err_nxt   = 1'b0;
               w_flush_nxt = 1'b0;
`ifndef RR_TRACE_WB_WRAP_EN
               w_full_nxt  = 1'b0;
`endif
               w_state_nxt = StWait;
            end
         end
         StWait: begin
`ifndef RR_TRACE_WB_WRAP_EN
            if (r_full) begin
               // Buffer exhausted: words still queued at flush time are lost.
               if (w_flush_now) begin
                  w_state_nxt = StDone;
                  if (!i_fifo_empty) w_err_nxt = 1'b1;
               end
            end else
`endif
            if (i_fifo_cnt >= CNT_WIDTH'(BURST_LEN)) begin
               w_beats_nxt = BEAT_W'(BURST_LEN);
               w_state_nxt = StAw;
            end else if (w_flush_now && !i_fifo_empty) begin
               w_beats_nxt = BEAT_W'(i_fifo_cnt);
               w_state_nxt = StAw;
            end else if (w_flush_now) begin
               w_state_nxt = StDone;
            end
         end
         StAw: begin
            if (m_axi.awready) begin
               w_cnt_nxt   = r_beats;
               w_state_nxt = StW;
            end
         end
         StW: begin
            if (w_hs) begin
               w_cnt_nxt = r_cnt - BEAT_W'(1);
               if (r_cnt == BEAT_W'(1)) w_state_nxt = StB;
            end
         end
         StB: begin
            if (m_axi.bvalid) begin
               w_bytes_nxt = r_bytes + w_burst_bytes;
               if (m_axi.bresp != 2'b00) w_err_nxt = 1'b1;
               w_ptr_nxt = w_ptr_inc;
               if (w_ptr_inc == r_end) begin
`ifdef RR_TRACE_WB_WRAP_EN
                  w_ptr_nxt        = r_base;
                  w_wrap_pulse_nxt = 1'b1;
`else
                  w_full_nxt       = 1'b1;
`endif
               end
               w_state_nxt = (w_flush_now && i_fifo_empty) ? StDone : StWait;
            end
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   // Byte strobe from the head word's valid-bit count; saturates at a full beat.
   always_comb begin
      w_size_bytes = i_fifo_size >> 3;
      w_strb       = '0;
      for (int unsigned i = 0; i < BB; i++) begin
         w_strb[i] = (OFFSET_WIDTH'(i) < w_size_bytes);
      end
   end

   assign m_axi.awvalid = (r_state == StAw);
   assign m_axi.awaddr  = (r_state == StAw) ? r_ptr : '0;
   assign m_axi.awlen   = (r_state == StAw) ? 8'(r_beats - BEAT_W'(1)) : 8'h00;
   assign m_axi.wvalid  = w_wvalid;
   assign m_axi.wdata   = w_wvalid ? i_fifo_dout : '0;
   assign m_axi.wstrb   = w_wvalid ? w_strb : '0;
   assign m_axi.wlast   = w_wvalid & (r_cnt == BEAT_W'(1));
   assign m_axi.bready  = (r_state == StB);
   assign o_fifo_rd_en  = w_hs;
   assign o_wr_bytes    = r_bytes;
   assign o_busy        = (r_state == StWait) | (r_state == StAw) | (r_state == StW) |
                          (r_state == StB);
   assign o_done        = (r_state == StDone);
   assign o_err         = r_err;
`ifdef RR_TRACE_WB_WRAP_EN
   assign o_buf_full    = r_wrap_pulse;
`else
   assign o_buf_full    = r_full;
`endif

endmodule

// File: tb/tb_rr_trace_wb_ctrl.sv
// Randomized self-checking bench: FIFO model, AXI slave model and burst-plan reference model.
module tb_rr_trace_wb_ctrl;
   localparam int unsigned DW = 512;
   localparam int unsigned AW = 64;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cfg_start, record_finish;
   logic [AW-1:0] buf_base, buf_size;
   logic [DW-1:0] fifo_dout;
   logic [31:0]   fifo_size;
   logic [9:0]    fifo_cnt;
   logic          fifo_empty, fifo_rd_en;
   logic [AW-1:0] wr_bytes;
   logic          busy, done, err, buf_full;

   rr_trace_wb_ctrl_if #(.AXI_WIDTH(DW), .AXI_ADDR_WIDTH(AW)) u_axi ();

   rr_trace_wb_ctrl u_dut (
      .clk(clk), .rst_n(rst_n), .i_cfg_start(cfg_start), .i_buf_base(buf_base),
      .i_buf_size(buf_size), .i_record_finish(record_finish), .i_fifo_dout(fifo_dout),
      .i_fifo_size(fifo_size), .i_fifo_cnt(fifo_cnt), .i_fifo_empty(fifo_empty),
      .o_fifo_rd_en(fifo_rd_en), .m_axi(u_axi), .o_wr_bytes(wr_bytes), .o_busy(busy),
      .o_done(done), .o_err(err), .o_buf_full(buf_full)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // FIFO contents and the in-order copy expected on the W channel
   logic [DW-1:0] q_data[$];
   int            q_size[$];
   logic [DW-1:0] e_data[$];
   int            e_size[$];

   bit pend_cfg, pend_fin, timed_out;
   int aw_pct, w_pct, aw_delay, bad_b;

   logic [AW-1:0] obs_aw_addr[$];
   int            obs_aw_len[$];
   int            obs_beats, obs_beat_err, obs_aw_unstable, obs_b_cnt, obs_full_cycles, obs_rd_full;
   logic [63:0]   obs_last_strb;
   int            cur_beat, cur_len, b_pend, b_delay, aw_wait;
   bit            aw_prev_v;
   logic [AW-1:0] aw_prev_addr;
   logic [7:0]    aw_prev_len;

   task automatic clear_all();
      q_data.delete(); q_size.delete(); e_data.delete(); e_size.delete();
      obs_aw_addr.delete(); obs_aw_len.delete();
      obs_beats = 0; obs_beat_err = 0; obs_aw_unstable = 0; obs_b_cnt = 0;
      obs_full_cycles = 0; obs_rd_full = 0; obs_last_strb = '0;
      cur_beat = 0; cur_len = 0; b_pend = 0; b_delay = 0; aw_wait = 0; aw_prev_v = 0;
      aw_prev_addr = '0; aw_prev_len = '0;
      aw_pct = 100; w_pct = 100; aw_delay = 0; bad_b = -1;
   endtask

   task automatic push_word(input int sz);
      logic [DW-1:0] d;
      for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom();
      q_data.push_back(d); q_size.push_back(sz);
      e_data.push_back(d); e_size.push_back(sz);
   endtask

   task automatic step();
      logic [DW-1:0] ed;
      logic [63:0]   es_strb;
      int            es;
      cfg_start = pend_cfg; record_finish = pend_fin;
      pend_cfg = 0; pend_fin = 0;
      fifo_cnt   = 10'(q_data.size());
      fifo_empty = (q_data.size() == 0);
      fifo_dout  = fifo_empty ? '0 : q_data[0];
      fifo_size  = fifo_empty ? 32'd512 : 32'(q_size[0]);
      u_axi.awready = (aw_wait >= aw_delay) && ($urandom_range(99) < aw_pct);
      u_axi.wready  = ($urandom_range(99) < w_pct);
      u_axi.bvalid  = (b_pend != 0) && (b_delay == 0);
      u_axi.bresp   = (u_axi.bvalid && obs_b_cnt == bad_b) ? 2'b10 : 2'b00;
      #1;
      if (u_axi.awvalid) begin
         if (aw_prev_v && (u_axi.awaddr !== aw_prev_addr || u_axi.awlen !== aw_prev_len))
            obs_aw_unstable++;
         if (u_axi.awready) begin
            obs_aw_addr.push_back(u_axi.awaddr); obs_aw_len.push_back(int'(u_axi.awlen));
            cur_len = int'(u_axi.awlen) + 1; cur_beat = 0; aw_wait = 0; aw_prev_v = 0;
         end else begin
            aw_wait++; aw_prev_v = 1;
            aw_prev_addr = u_axi.awaddr; aw_prev_len = u_axi.awlen;
         end
      end else begin
         if (aw_prev_v) obs_aw_unstable++;
         aw_prev_v = 0;
      end
      if (fifo_rd_en !== (u_axi.wvalid && u_axi.wready)) obs_beat_err++;
      if (u_axi.wvalid && u_axi.wready) begin
         if (e_data.size() == 0) obs_beat_err++;
         else begin
            ed = e_data.pop_front(); es = e_size.pop_front();
            for (int i = 0; i < 64; i++) es_strb[i] = (i < es / 8);
            if (u_axi.wdata !== ed) obs_beat_err++;
            if (u_axi.wstrb !== es_strb) obs_beat_err++;
         end
         if (u_axi.wlast !== (cur_beat == cur_len - 1)) obs_beat_err++;
         obs_last_strb = u_axi.wstrb; cur_beat++; obs_beats++;
         if (u_axi.wlast) begin b_pend = 1; b_delay = $urandom_range(2); end
      end
      if (fifo_rd_en && q_data.size() > 0) begin
         void'(q_data.pop_front()); void'(q_size.pop_front());
      end
      if (u_axi.bvalid && u_axi.bready) begin b_pend = 0; obs_b_cnt++; end
      else if (b_pend != 0 && b_delay > 0) b_delay--;
      if (buf_full) obs_full_cycles++;
      if (buf_full && fifo_rd_en) obs_rd_full++;
      @(posedge clk); @(negedge clk);
   endtask

   // mode 0: until done; 1: until target B responses; 2: until target beats; 3: fixed cycles
   task automatic run(input int max_cyc, input int mode, input int target);
      timed_out = 0;
      for (int c = 0; ; c++) begin
         if (mode == 0 && done) break;
         if (mode == 1 && obs_b_cnt >= target) break;
         if (mode == 2 && obs_beats >= target) break;
         if (c >= max_cyc) begin timed_out = (mode != 3); break; end
         step();
      end
   endtask

   task automatic start(input logic [AW-1:0] base, input logic [AW-1:0] size, input bit fin);
      buf_base = base; buf_size = size; pend_cfg = 1; step();
      if (fin) pend_fin = 1;
   endtask

   task automatic test_reset();
      #1;
      n_checks++;
      if ({busy, done, err, buf_full, u_axi.awvalid, u_axi.wvalid, fifo_rd_en, u_axi.bready}
          !== 8'h00) begin
         n_errors++;
         $display("FAIL reset_outputs: got %b want 00000000", {busy, done, err, buf_full,
                  u_axi.awvalid, u_axi.wvalid, fifo_rd_en, u_axi.bready});
      end
      n_checks++;
      if (wr_bytes !== 64'd0) begin
         n_errors++; $display("FAIL reset_wr_bytes: got %0d want 0", wr_bytes);
      end
   endtask

   task automatic test_single_burst();
      logic [AW-1:0] a0;
      clear_all();
      for (int i = 0; i < 16; i++) push_word(512);
      start(64'h1000, 64'h8000, 0);
      run(200, 1, 1);
      a0 = (obs_aw_addr.size() > 0) ? obs_aw_addr[0] : '1;
      n_checks++;
      if (timed_out || obs_aw_addr.size() != 1 || a0 !== 64'h1000 || obs_aw_len[0] != 15) begin
         n_errors++;
         $display("FAIL t1_aw: got n=%0d addr=%h to=%0d want n=1 addr=1000 len=15",
                  obs_aw_addr.size(), a0, timed_out);
      end
      n_checks++;
      if (obs_beats != 16 || obs_beat_err != 0) begin
         n_errors++; $display("FAIL t1_beats: got %0d beats %0d errs want 16/0", obs_beats,
                              obs_beat_err);
      end
      n_checks++;
      if (wr_bytes !== 64'd1024) begin
         n_errors++; $display("FAIL t1_wr_bytes: got %0d want 1024", wr_bytes);
      end
      n_checks++;
      if ({busy, done} !== 2'b10) begin
         n_errors++; $display("FAIL t1_idle_wait: got busy,done=%b want 10", {busy, done});
      end
      pend_fin = 1;
      run(20, 0, 0);
      n_checks++;
      if (timed_out || done !== 1'b1) begin
         n_errors++; $display("FAIL t1_done: got %b want 1", done);
      end
   endtask

   task automatic test_flush_partial();
      logic [AW-1:0] a0;
      clear_all();
      for (int i = 0; i < 4; i++) push_word(512);
      push_word(96);
      start(64'h2000, 64'h8000, 1);
      run(200, 0, 0);
      a0 = (obs_aw_addr.size() > 0) ? obs_aw_addr[0] : '1;
      n_checks++;
      if (timed_out || obs_aw_addr.size() != 1 || a0 !== 64'h2000 || obs_aw_len[0] != 4) begin
         n_errors++;
         $display("FAIL t2_aw: got n=%0d addr=%h to=%0d want n=1 addr=2000 len=4",
                  obs_aw_addr.size(), a0, timed_out);
      end
      n_checks++;
      if (obs_beats != 5 || obs_beat_err != 0) begin
         n_errors++; $display("FAIL t2_beats: got %0d/%0d want 5/0", obs_beats, obs_beat_err);
      end
      n_checks++;
      if (obs_last_strb !== 64'hFFF) begin
         n_errors++; $display("FAIL t2_last_wstrb: got %h want fff", obs_last_strb);
      end
      n_checks++;
      if (done !== 1'b1 || wr_bytes !== 64'd320) begin
         n_errors++; $display("FAIL t2_done: got done=%b bytes=%0d want 1/320", done, wr_bytes);
      end
   endtask

   task automatic test_backpressure();
      clear_all();
      for (int i = 0; i < 32; i++) push_word(512);
      aw_delay = 10; w_pct = 50;
      start(64'h3000, 64'h8000, 1);
      run(2000, 0, 0);
      n_checks++;
      if (timed_out || obs_aw_addr.size() != 2 || obs_aw_addr[0] !== 64'h3000 ||
          obs_aw_addr[1] !== 64'h3400) begin
         n_errors++;
         $display("FAIL t3_aw: got n=%0d to=%0d want 2 bursts at 3000,3400",
                  obs_aw_addr.size(), timed_out);
      end
      n_checks++;
      if (obs_aw_unstable != 0) begin
         n_errors++; $display("FAIL t3_aw_stable: got %0d changes want 0", obs_aw_unstable);
      end
      n_checks++;
      if (obs_beats != 32 || obs_beat_err != 0 || q_data.size() != 0) begin
         n_errors++; $display("FAIL t3_beats: got %0d/%0d left=%0d want 32/0/0", obs_beats,
                              obs_beat_err, q_data.size());
      end
      n_checks++;
      if (wr_bytes !== 64'd2048) begin
         n_errors++; $display("FAIL t3_wr_bytes: got %0d want 2048", wr_bytes);
      end
   endtask

   task automatic test_bresp_err();
      clear_all();
      for (int i = 0; i < 48; i++) push_word(512);
      bad_b = 1;
      start(64'h6000, 64'h8000, 1);
      run(1000, 0, 0);
      n_checks++;
      if (timed_out || obs_aw_addr.size() != 3 || obs_beats != 48 || obs_beat_err != 0) begin
         n_errors++; $display("FAIL t4_bursts: got n=%0d beats=%0d errs=%0d want 3/48/0",
                              obs_aw_addr.size(), obs_beats, obs_beat_err);
      end
      n_checks++;
      if (err !== 1'b1 || done !== 1'b1 || wr_bytes !== 64'd3072) begin
         n_errors++; $display("FAIL t4_status: got err=%b done=%b bytes=%0d want 1/1/3072",
                              err, done, wr_bytes);
      end
      run(5, 3, 0);
      n_checks++;
      if (err !== 1'b1) begin
         n_errors++; $display("FAIL t4_err_sticky: got %b want 1", err);
      end
   endtask

   task automatic test_buf_end();
      clear_all();
      for (int i = 0; i < 48; i++) push_word(512);
      start(64'h4000, 64'h800, 0);
      n_checks++;
      if (err !== 1'b0) begin
         n_errors++; $display("FAIL t5_err_cleared: got %b want 0", err);
      end
      run(400, 1, 2);
`ifdef RR_TRACE_WB_WRAP_EN
      run(400, 1, 3);
      n_checks++;
      if (timed_out || obs_aw_addr.size() != 3 || obs_aw_addr[2] !== 64'h4000) begin
         n_errors++; $display("FAIL t5_wrap_addr: got n=%0d to=%0d want 3rd at 4000",
                              obs_aw_addr.size(), timed_out);
      end
      pend_fin = 1;
      run(50, 0, 0);
      n_checks++;
      if (obs_full_cycles != 1) begin
         n_errors++; $display("FAIL t5_buf_full_pulse: got %0d cycles want 1", obs_full_cycles);
      end
      n_checks++;
      if (done !== 1'b1 || err !== 1'b0 || wr_bytes !== 64'd3072) begin
         n_errors++; $display("FAIL t5_done: got done=%b err=%b bytes=%0d want 1/0/3072",
                              done, err, wr_bytes);
      end
`else
      run(60, 3, 0);
      n_checks++;
      if (obs_aw_addr.size() != 2 || obs_beats != 32 || q_data.size() != 16) begin
         n_errors++; $display("FAIL t5_stall: got n=%0d beats=%0d left=%0d want 2/32/16",
                              obs_aw_addr.size(), obs_beats, q_data.size());
      end
      n_checks++;
      if (buf_full !== 1'b1 || busy !== 1'b1 || obs_rd_full != 0) begin
         n_errors++; $display("FAIL t5_buf_full: got full=%b busy=%b rd=%0d want 1/1/0",
                              buf_full, busy, obs_rd_full);
      end
      pend_fin = 1;
      run(20, 0, 0);
      n_checks++;
      if (done !== 1'b1 || err !== 1'b1 || wr_bytes !== 64'd2048) begin
         n_errors++; $display("FAIL t5_done: got done=%b err=%b bytes=%0d want 1/1/2048",
                              done, err, wr_bytes);
      end
`endif
   endtask

   task automatic test_random();
      logic [AW-1:0] base, ptr;
      logic [AW-1:0] exp_addr[$];
      int            exp_len[$];
      int            n, rem, bad;
      for (int it = 0; it < 6; it++) begin
         clear_all();
         n = $urandom_range(1, 40);
         for (int i = 0; i < n; i++) push_word(8 * $urandom_range(1, 64));
         aw_pct = $urandom_range(30, 100); w_pct = $urandom_range(30, 100);
         base = AW'($urandom_range(1, 255)) << 12;
         // Reference plan: full bursts first, remainder as one flush burst
         exp_addr.delete(); exp_len.delete();
         rem = n; ptr = base;
         while (rem > 0) begin
            exp_addr.push_back(ptr); exp_len.push_back(((rem >= 16) ? 16 : rem) - 1);
            ptr += 64 * ((rem >= 16) ? 16 : rem);
            rem -= (rem >= 16) ? 16 : rem;
         end
         start(base, 64'h10000, 1);
         run(3000, 0, 0);
         bad = (obs_aw_addr.size() != exp_addr.size()) ? 1 : 0;
         if (bad == 0)
            for (int k = 0; k < exp_addr.size(); k++)
               if (obs_aw_addr[k] !== exp_addr[k] || obs_aw_len[k] != exp_len[k]) bad = 1;
         n_checks++;
         if (timed_out || bad != 0) begin
            n_errors++; $display("FAIL rnd%0d_bursts: got n=%0d to=%0d want n=%0d", it,
                                 obs_aw_addr.size(), timed_out, exp_addr.size());
         end
         n_checks++;
         if (obs_beats != n || obs_beat_err != 0) begin
            n_errors++; $display("FAIL rnd%0d_beats: got %0d/%0d want %0d/0", it, obs_beats,
                                 obs_beat_err, n);
         end
         n_checks++;
         if (done !== 1'b1 || wr_bytes !== AW'(64 * n)) begin
            n_errors++; $display("FAIL rnd%0d_done: got done=%b bytes=%0d want 1/%0d", it,
                                 done, wr_bytes, 64 * n);
         end
      end
   endtask

   task automatic test_reset_mid_w();
      clear_all();
      for (int i = 0; i < 16; i++) push_word(512);
      start(64'h5000, 64'h8000, 0);
      run(100, 2, 3);
      n_checks++;
      if (timed_out || u_axi.wvalid !== 1'b1) begin
         n_errors++; $display("FAIL t6_in_w: got wvalid=%b to=%0d want 1/0", u_axi.wvalid,
                              timed_out);
      end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({u_axi.awvalid, u_axi.wvalid, fifo_rd_en} !== 3'b000) begin
         n_errors++; $display("FAIL t6_async_drop: got %b want 000",
                              {u_axi.awvalid, u_axi.wvalid, fifo_rd_en});
      end
      @(negedge clk);
      rst_n = 1'b1;
      clear_all();
      step();
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0 || wr_bytes !== 64'd0) begin
         n_errors++; $display("FAIL t6_after_reset: got busy=%b done=%b bytes=%0d want 0/0/0",
                              busy, done, wr_bytes);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; cfg_start = 0; record_finish = 0; buf_base = '0; buf_size = '0;
      fifo_dout = '0; fifo_size = 32'd512; fifo_cnt = '0; fifo_empty = 1'b1;
      u_axi.awready = 0; u_axi.wready = 0; u_axi.bvalid = 0; u_axi.bresp = 2'b00;
      pend_cfg = 0; pend_fin = 0;
      clear_all();
      repeat (3) @(negedge clk);
      test_reset();
      rst_n = 1'b1;
      @(negedge clk);
      test_reset();
      test_single_burst();
      test_flush_partial();
      test_backpressure();
      test_bresp_err();
      test_buf_end();
      test_random();
      test_reset_mid_w();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
